// File: rtl/flash_ctrl.sv
// Purpose: read-only SPI flash bus slave; wakes the flash with 0xAB after reset, then serves each word read as a single-IO READ (0x03).
// Latency: ready_out pulses 128*CLK_DIV+2 cycles after the accepting IDLE cycle for reads, and 1 cycle after acceptance for writes.
// Backpressure: requests are held off (no ready_out) during wake, transactions and deselect; the requester holds its request until ready_out.
//
// Ports:
//   clk, reset_n                  system clock, asynchronous active-low reset
//   address_in/sel_in/read_in     bus request; address bits [23:2] pick the flash word
//   write_mask_in/write_value_in  bus write; acknowledged without touching the flash
//   read_value_out/ready_out      read data (gated by sel_in && ready_out) and one-cycle completion pulse
//   flash_*                       SPI mode-0 pins; io1 is input only (MISO)
module flash_ctrl #(
    parameter int CLK_DIV         = 1,
    parameter int WAKE_CYCLES     = 72,
    parameter int DESELECT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic        flash_clk,
    output logic        flash_csn,
    output logic        flash_io0_out,
    output logic        flash_io0_en,
    input  logic        flash_io1_in,
    output logic        flash_io1_out,
    output logic        flash_io1_en
);

    typedef enum logic [2:0] {
        WAKE_CMD,
        WAKE_WAIT,
        IDLE,
        CMD,
        DATA,
        DONE,
        DESEL
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        csn_q;
    logic        sck_q;
    logic        ready_q;
    logic [7:0]  div_cnt;
    logic [6:0]  bit_cnt;
    logic [15:0] wait_cnt;
    logic [31:0] tx_q;
    logic [31:0] rx_q;
    logic [31:0] data_q;

    logic        spi_run;
    logic        half_end;
    logic        bit_end;
    logic        wait_last;
    logic        rd_acc;
    logic        wr_acc;
    logic        nxt_active;

    // The bit engine only runs once csn is actually low, so the first
    // WAKE_CMD cycle after reset is a setup cycle that loads 0xAB and drops csn.
    assign spi_run  = !csn_q && (state == WAKE_CMD || state == CMD || state == DATA);
    assign half_end = spi_run && (div_cnt == 8'(CLK_DIV - 1));
    assign bit_end  = half_end && sck_q;

    assign wait_last = (state == WAKE_WAIT && wait_cnt == 16'(WAKE_CYCLES - 1)) ||
                       (state == DESEL     && wait_cnt == 16'(DESELECT_CYCLES - 1));

    // ready_q blocks re-acceptance in the cycle the previous pulse is out,
    // since the requester only drops its request after seeing ready_out.
    assign rd_acc = (state == IDLE) && !ready_q && sel_in && read_in;
    assign wr_acc = (state == IDLE) && !ready_q && sel_in && !read_in && (write_mask_in != 4'd0);

    assign nxt_active = (state_nxt == WAKE_CMD) || (state_nxt == CMD) || (state_nxt == DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAKE_CMD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAKE_CMD:  if (bit_end && bit_cnt == 7'd7)  state_nxt = WAKE_WAIT;
            WAKE_WAIT: if (wait_last)                   state_nxt = IDLE;
            IDLE:      if (rd_acc)                      state_nxt = CMD;
            CMD:       if (bit_end && bit_cnt == 7'd31) state_nxt = DATA;
            DATA:      if (bit_end && bit_cnt == 7'd63) state_nxt = DONE;
            DONE:                                       state_nxt = DESEL;
            DESEL:     if (wait_last)                   state_nxt = IDLE;
            default:                                    state_nxt = WAKE_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csn_q    <= 1'b1;
            sck_q    <= 1'b0;
            ready_q  <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            data_q   <= '0;
        end else begin
            csn_q   <= !nxt_active;
            ready_q <= (state == DONE) || wr_acc;

            // Each bit: CLK_DIV cycles low, CLK_DIV cycles high. MOSI shifts on
            // the falling edge, MISO is captured on the rising edge.
            if (spi_run) begin
                if (half_end) begin
                    div_cnt <= '0;
                    sck_q   <= !sck_q;
                    if (sck_q) begin
                        tx_q    <= {tx_q[30:0], 1'b0};
                        bit_cnt <= bit_cnt + 7'd1;
                    end else if (state == DATA) begin
                        rx_q <= {rx_q[30:0], flash_io1_in};
                    end
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end else begin
                div_cnt <= '0;
                sck_q   <= 1'b0;
                bit_cnt <= '0;
            end

            if (state == WAKE_CMD && csn_q) begin
                tx_q <= {8'hAB, 24'h0};
            end else if (rd_acc) begin
                tx_q <= {8'h03, address_in[23:2], 2'b00};
            end

            if (state == WAKE_WAIT || state == DESEL) begin
                wait_cnt <= wait_last ? 16'd0 : wait_cnt + 16'd1;
            end else begin
                wait_cnt <= '0;
            end

            // First byte off the wire lands in bits [7:0] (little-endian word).
            if (state == DONE) begin
                data_q <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            end
        end
    end

    assign read_value_out = (sel_in && ready_q) ? data_q : 32'd0;
    assign ready_out      = ready_q;
    assign flash_clk      = sck_q;
    assign flash_csn      = csn_q;
    assign flash_io0_out  = tx_q[31];
    assign flash_io0_en   = 1'b1;
    assign flash_io1_out  = 1'b0;
    assign flash_io1_en   = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{write_value_in, address_in[31:24], address_in[1:0]};

endmodule

// File: tb/tb_flash_ctrl.sv
module tb_flash_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [1:0]        sel, rd, rdy;
    logic [1:0]        f_clk, f_csn, f_io0, f_io0_en, f_miso, f_io1_out, f_io1_en;
    logic [31:0]       addr, wval;
    logic [3:0]        mask;
    logic [1:0][31:0]  rv;

    flash_ctrl #(.CLK_DIV(1), .WAKE_CYCLES(72), .DESELECT_CYCLES(2)) u_div1 (
        .clk(clk), .reset_n(reset_n), .address_in(addr), .sel_in(sel[0]), .read_in(rd[0]),
        .write_mask_in(mask), .write_value_in(wval), .read_value_out(rv[0]), .ready_out(rdy[0]),
        .flash_clk(f_clk[0]), .flash_csn(f_csn[0]), .flash_io0_out(f_io0[0]), .flash_io0_en(f_io0_en[0]),
        .flash_io1_in(f_miso[0]), .flash_io1_out(f_io1_out[0]), .flash_io1_en(f_io1_en[0])
    );

    flash_ctrl #(.CLK_DIV(3), .WAKE_CYCLES(72), .DESELECT_CYCLES(2)) u_div3 (
        .clk(clk), .reset_n(reset_n), .address_in(addr), .sel_in(sel[1]), .read_in(rd[1]),
        .write_mask_in(mask), .write_value_in(wval), .read_value_out(rv[1]), .ready_out(rdy[1]),
        .flash_clk(f_clk[1]), .flash_csn(f_csn[1]), .flash_io0_out(f_io0[1]), .flash_io0_en(f_io0_en[1]),
        .flash_io1_in(f_miso[1]), .flash_io1_out(f_io1_out[1]), .flash_io1_en(f_io1_en[1])
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Flash content: the word at 0x1234 holds bytes 11,22,33,44; elsewhere byte j = addr[7:0]+j.
    function automatic logic flash_bit(input logic [23:0] a, input int k);
        logic [7:0] b;
        int j;
        j = k / 8;
        if (a == 24'h001234) b = 8'(8'h11 * (j + 1));
        else                 b = a[7:0] + 8'(j);
        return b[7 - (k % 8)];
    endfunction

    // Per-instance pin monitor and flash model, sampled 1 ns after each clk edge.
    int          n_txn[2], nbits[2], fall_cyc[2], rise_cyc[2], last_gap[2];
    int          last_bits[2], first_bits[2], rise_sck_cyc[2], sck_period[2], stab_err[2];
    logic [63:0] mosi[2], last_mosi[2], first_mosi[2];
    logic [23:0] cur_addr[2];
    logic        prev_csn[2], prev_sck[2], prev_io0[2];

    initial begin
        f_miso = '0;
        for (int i = 0; i < 2; i++) begin
            n_txn[i] = 0; nbits[i] = 0; fall_cyc[i] = 0; rise_cyc[i] = 0; last_gap[i] = 0;
            last_bits[i] = 0; first_bits[i] = 0; rise_sck_cyc[i] = 0; sck_period[i] = 0;
            stab_err[i] = 0; mosi[i] = '0; last_mosi[i] = '0; first_mosi[i] = '0;
            cur_addr[i] = '0; prev_csn[i] = 1'b1; prev_sck[i] = 1'b0; prev_io0[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!f_csn[i] && prev_csn[i]) begin
                n_txn[i]++;
                nbits[i]    = 0;
                mosi[i]     = '0;
                fall_cyc[i] = cyc;
                last_gap[i] = cyc - rise_cyc[i];
            end
            if (f_csn[i] && !prev_csn[i]) begin
                rise_cyc[i]  = cyc;
                last_bits[i] = nbits[i];
                last_mosi[i] = mosi[i];
                if (n_txn[i] == 1) begin
                    first_bits[i] = nbits[i];
                    first_mosi[i] = mosi[i];
                end
            end
            if (!f_csn[i] && f_clk[i] && !prev_sck[i]) begin
                mosi[i] = {mosi[i][62:0], f_io0[i]};
                nbits[i]++;
                sck_period[i]   = cyc - rise_sck_cyc[i];
                rise_sck_cyc[i] = cyc;
                if (nbits[i] == 32) cur_addr[i] = mosi[i][23:0];
            end
            // MOSI may only change while SCK is low.
            if (f_clk[i] && (f_io0[i] !== prev_io0[i])) stab_err[i]++;
            if (!f_csn[i] && !f_clk[i] && nbits[i] >= 32 && nbits[i] < 64)
                f_miso[i] = flash_bit(cur_addr[i], nbits[i] - 32);
            else
                f_miso[i] = 1'b0;
            prev_csn[i] = f_csn[i];
            prev_sck[i] = f_clk[i];
            prev_io0[i] = f_io0[i];
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [3:0]  m;
        logic [31:0] exp_data;
        logic [31:0] exp_cmd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    // Issues one request on instance i and checks it. Read latency is measured
    // from the accepting IDLE cycle (the cycle before csn falls).
    task automatic run_vec(input int i, input vec_t v, input string nm);
        int  t0, n0, lat;
        bit  got, bad;
        if (v.wr) begin
            sel[i] = 1'b0; rd[i] = 1'b0;
            repeat (4) @(posedge clk);
            #2;
        end
        addr = v.a; mask = v.m; rd[i] = !v.wr; sel[i] = 1'b1;
        t0 = cyc; n0 = n_txn[i];
        got = 1'b0; bad = 1'b0;
        for (int w = 0; w < 3000 && !got; w++) begin
            @(posedge clk);
            #2;
            if (rdy[i]) got = 1'b1;
            else if (rv[i] !== 32'd0) bad = 1'b1;
        end
        check({nm, "_ready"}, 64'(got), 64'd1);
        check({nm, "_rv_zero_when_not_ready"}, 64'(bad), 64'd0);
        if (v.wr) begin
            check({nm, "_wr_latency"}, 64'(cyc - t0), 64'(v.exp_lat));
            check({nm, "_wr_no_csn"}, 64'(n_txn[i] - n0), 64'd0);
        end else begin
            lat = cyc - (fall_cyc[i] - 1);
            check({nm, "_rd_latency"}, 64'(lat), 64'(v.exp_lat));
            check({nm, "_rd_data"}, 64'(rv[i]), 64'(v.exp_data));
            check({nm, "_rd_cmd"}, 64'(last_mosi[i][63:32]), 64'(v.exp_cmd));
            check({nm, "_rd_bits"}, 64'(last_bits[i]), 64'd64);
        end
    endtask

    initial begin
        int  rel;
        bit  got, early;
        vec_t v;

        vecs[0] = '{1'b0, 32'h0000_1234, 4'h0, 32'h4433_2211, 32'h0300_1234, 130};
        vecs[1] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0302_0100, 32'h0300_0000, 130};
        vecs[2] = '{1'b0, 32'h0000_0004, 4'h0, 32'h0706_0504, 32'h0300_0004, 130};
        vecs[3] = '{1'b1, 32'h0000_0010, 4'hF, 32'h0,         32'h0,         1};
        vecs[4] = '{1'b0, 32'h0000_1234, 4'h0, 32'h4433_2211, 32'h0300_1234, 130};
        vecs[5] = '{1'b0, 32'hFF00_0ABE, 4'h0, 32'hBFBE_BDBC, 32'h0300_0ABC, 130};
        vecs[6] = '{1'b1, 32'h0000_0020, 4'h1, 32'h0,         32'h0,         1};

        reset_n = 1'b0; sel = '0; rd = '0; addr = '0; mask = '0; wval = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #2;
        check("rst_csn",     64'(f_csn),    64'h3);
        check("rst_sck",     64'(f_clk),    64'h0);
        check("rst_io0",     64'(f_io0),    64'h0);
        check("rst_io0_en",  64'(f_io0_en), 64'h3);
        check("rst_io1_en",  64'(f_io1_en), 64'h0);
        check("rst_ready",   64'(rdy),      64'h0);
        check("rst_rv",      64'(rv[0]),    64'h0);

        // Release reset with the first read already pending: it is held off through wake.
        reset_n = 1'b1;
        rel = cyc;
        for (int k = 0; k < 7; k++) begin
            run_vec(0, vecs[k], $sformatf("vec%0d", k));
            if (k == 0) begin
                check("wake_bits",      64'(first_bits[0]), 64'd8);
                check("wake_cmd",       64'(first_mosi[0][7:0]), 64'hAB);
                check("wake_gap_ge72",  64'(last_gap[0] >= 72), 64'd1);
                check("wake_ready_late", 64'((cyc - rel) >= 218), 64'd1);
            end
            if (k == 2) check("b2b_desel_ge2", 64'(last_gap[0] >= 2), 64'd1);
        end
        sel[0] = 1'b0; rd[0] = 1'b0;

        // CLK_DIV=3 instance: 6-cycle SCK period and 386-cycle latency.
        v = '{1'b0, 32'h0000_1234, 4'h0, 32'h4433_2211, 32'h0300_1234, 386};
        run_vec(1, v, "div3");
        check("div3_sck_period", 64'(sck_period[1]), 64'd6);
        @(posedge clk);
        #2;
        check("div3_ready_one_cycle", 64'(rdy[1]), 64'd0);
        sel[1] = 1'b0; rd[1] = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        // sel_in dropped mid-transaction: completion still pulses, data gated off.
        begin
            int n0;
            n0 = n_txn[1];
            addr = 32'h0000_1234; sel[1] = 1'b1; rd[1] = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                @(posedge clk);
                #2;
                if (n_txn[1] != n0) got = 1'b1;
            end
            sel[1] = 1'b0;
            got = 1'b0;
            for (int w = 0; w < 1000 && !got; w++) begin
                @(posedge clk);
                #2;
                if (rdy[1]) got = 1'b1;
            end
            check("seldrop_ready", 64'(got), 64'd1);
            check("seldrop_rv_gated", 64'(rv[1]), 64'd0);
            rd[1] = 1'b0;
        end
        repeat (4) @(posedge clk);
        #2;

        // Reset at bit 40 of a read aborts at once and restarts the wake sequence.
        begin
            int n0;
            n0 = n_txn[0];
            addr = 32'h0000_0000; sel[0] = 1'b1; rd[0] = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 300 && !got; w++) begin
                @(posedge clk);
                #2;
                if (n_txn[0] != n0 && nbits[0] >= 40) got = 1'b1;
            end
            check("abort_reached_bit40", 64'(got), 64'd1);
            reset_n = 1'b0;
            #1;
            check("abort_csn",   64'(f_csn[0]), 64'd1);
            check("abort_sck",   64'(f_clk[0]), 64'd0);
            check("abort_ready", 64'(rdy[0]),   64'd0);
            repeat (2) @(posedge clk);
            #2;
            n0 = n_txn[0];
            reset_n = 1'b1;
            got = 1'b0; early = 1'b0;
            for (int w = 0; w < 200 && !got; w++) begin
                @(posedge clk);
                #2;
                if (rdy[0]) early = 1'b1;
                if (n_txn[0] != n0 && f_csn[0]) got = 1'b1;
            end
            check("rewake_seen",     64'(got), 64'd1);
            check("rewake_bits",     64'(last_bits[0]), 64'd8);
            check("rewake_cmd",      64'(last_mosi[0][7:0]), 64'hAB);
            check("abort_no_ready",  64'(early), 64'd0);
            sel[0] = 1'b0; rd[0] = 1'b0;
        end

        check("io0_stable_div1", 64'(stab_err[0]), 64'd0);
        check("io0_stable_div3", 64'(stab_err[1]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
